// File: rtl/hz_pkg.sv
// Shared constants and types for the pipeline hazard / forwarding controller.
package hz_pkg;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // One shadow-pipe entry: what an in-flight instruction will write back.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } shadow_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [31:0]      id_instr;
  logic             br_taken;
  logic             ext_stall;
  logic             stall_id;
  logic             flush_id;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_instr, br_taken, ext_stall,
    input  stall_id, flush_id, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_instr, br_taken, ext_stall,
    output stall_id, flush_id, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hz_decode.sv
// Combinational register-usage decoder for the instruction sitting in decode.
module hz_decode
  import hz_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_uses_rs1,
  output logic        o_uses_rs2,
  output logic        o_writes_rd,
  output logic        o_is_load
);

  logic [6:0] w_op;
  // funct3/funct7/immediate bits do not affect register usage.
  logic       w_unused_bits;

  assign w_op          = i_instr[6:0];
  assign o_rd          = i_instr[11:7];
  assign o_rs1         = i_instr[19:15];
  assign o_rs2         = i_instr[24:20];
  assign w_unused_bits = ^{i_instr[31:25], i_instr[14:12]};

  // Classify the opcode into register read/write usage.
  always_comb begin
    o_uses_rs1  = 1'b1;
    o_uses_rs2  = 1'b0;
    o_writes_rd = 1'b0;
    o_is_load   = 1'b0;
    case (w_op)
      OP_R:     begin o_uses_rs2 = 1'b1; o_writes_rd = 1'b1; end
      OP_I:     o_writes_rd = 1'b1;
      OP_LOAD:  begin o_writes_rd = 1'b1; o_is_load = 1'b1; end
      OP_STORE: o_uses_rs2 = 1'b1;
      OP_BR:    o_uses_rs2 = 1'b1;
      OP_JAL:   begin o_uses_rs1 = 1'b0; o_writes_rd = 1'b1; end
      OP_JALR:  o_writes_rd = 1'b1;
      OP_LUI:   begin o_uses_rs1 = 1'b0; o_writes_rd = 1'b1; end
      OP_AUIPC: begin o_uses_rs1 = 1'b0; o_writes_rd = 1'b1; end
      default:  ;
    endcase
    // x0 is never a real destination.
    if (o_rd == 5'd0) o_writes_rd = 1'b0;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a five-stage RV32I pipeline. Tracks EX/MEM/WB
// in a shadow pipe, raises load-use stalls and branch flushes, and registers the EX
// operand forwarding selects alongside the ID->EX transfer.
module pipeline_hazard_ctrl
  import hz_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic                   clk1,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  logic [4:0] w_rs1, w_rs2, w_rd;
  logic       w_uses_rs1, w_uses_rs2, w_writes_rd, w_is_load;

  hz_decode u_decode (
    .i_instr     (hz.id_instr),
    .o_rs1       (w_rs1),
    .o_rs2       (w_rs2),
    .o_rd        (w_rd),
    .o_uses_rs1  (w_uses_rs1),
    .o_uses_rs2  (w_uses_rs2),
    .o_writes_rd (w_writes_rd),
    .o_is_load   (w_is_load)
  );

  shadow_t          r_ex, r_mem, r_wb;
  shadow_t          w_id_entry;
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [1:0]       w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
  logic             w_load_use, w_flush, w_stall_lu;
  // WB is tracked for completeness; the register file is assumed write-through.
  logic             w_unused_wb;

  assign w_unused_wb = ^r_wb;

  // Source-register matches against the shadow EX and MEM entries (x0 excluded).
  always_comb begin
    w_ex_hit1  = w_uses_rs1 && (w_rs1 != 5'd0) && r_ex.valid && r_ex.wr && (r_ex.rd == w_rs1);
    w_ex_hit2  = w_uses_rs2 && (w_rs2 != 5'd0) && r_ex.valid && r_ex.wr && (r_ex.rd == w_rs2);
    w_mem_hit1 = w_uses_rs1 && (w_rs1 != 5'd0) && r_mem.valid && r_mem.wr &&
                 (r_mem.rd == w_rs1);
    w_mem_hit2 = w_uses_rs2 && (w_rs2 != 5'd0) && r_mem.valid && r_mem.wr &&
                 (r_mem.rd == w_rs2);
  end

  // Hazard decisions; a freeze masks both flush and load-use, flush masks load-use.
  always_comb begin
    w_load_use = hz.id_valid && r_ex.is_load && (w_ex_hit1 || w_ex_hit2);
    w_flush    = hz.br_taken && !hz.ext_stall;
    w_stall_lu = w_load_use && !w_flush && !hz.ext_stall;
  end

  // Entry and operand selects that move into EX on the next unfrozen edge.
  always_comb begin
    w_id_entry.valid   = hz.id_valid && !w_flush && !w_load_use;
    w_id_entry.rd      = w_rd;
    w_id_entry.wr      = w_writes_rd;
    w_id_entry.is_load = w_is_load;
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (w_id_entry.valid) begin
      // Newest producer wins; a load in EX never reaches here thanks to the stall.
      if (w_ex_hit1 && !r_ex.is_load) w_fwd_a = FWD_EXM;
      else if (w_mem_hit1)            w_fwd_a = FWD_MWB;
      if (w_ex_hit2 && !r_ex.is_load) w_fwd_b = FWD_EXM;
      else if (w_mem_hit2)            w_fwd_b = FWD_MWB;
    end
  end

  // Shadow pipe shift, forwarding select registers and saturating counters.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hz.ext_stall) begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_id_entry;
      r_fwd_a <= w_fwd_a;
      r_fwd_b <= w_fwd_b;
      if (w_stall_lu && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && (r_flush_cnt != '1))    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Mealy controls are forced low while reset is asserted.
  assign hz.stall_id  = rst_n && (hz.ext_stall || w_stall_lu);
  assign hz.flush_id  = rst_n && w_flush;
  assign hz.fwd_a_sel = r_fwd_a;
  assign hz.fwd_b_sel = r_fwd_b;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized instruction streams compared against an instruction-level model.
module tb_pipeline_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .hz    (bus)
  );

  always #5 clk1 = ~clk1;

  int n_tests = 0;
  int n_fail  = 0;

  // Current decode-stage instruction, described by kind and register numbers.
  int cur_k, cur_rd, cur_rs1, cur_rs2;
  bit cur_v, cur_br, cur_xs;
  bit last_stall = 1'b0;

  // Model of in-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
  // m_rd holds the destination written (0 when nothing is written).
  int m_v [3];
  int m_rd[3];
  bit m_ld[3];
  int m_fa, m_fb, m_sc, m_fc;

  function automatic logic [31:0] enc(input int k, input int rd, input int rs1, input int rs2);
    logic [6:0] op;
    logic [4:0] d, a, b;
    d = rd[4:0];
    a = rs1[4:0];
    b = rs2[4:0];
    case (k)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LD:    op = 7'b0000011;
      K_ST:    op = 7'b0100011;
      K_BR:    op = 7'b1100011;
      K_JAL:   op = 7'b1101111;
      K_JALR:  op = 7'b1100111;
      K_LUI:   op = 7'b0110111;
      default: op = 7'b0010111;
    endcase
    return {7'b0, b, a, 3'b000, d, op};
  endfunction

  // Which stage will hold the newest value of register r when the reader is in EX.
  function automatic int src(input int r);
    if (r == 0) return 0;
    if (m_v[0] != 0 && m_rd[0] == r && !m_ld[0]) return 1;
    if (m_v[1] != 0 && m_rd[1] == r) return 2;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input int k, input int rd, input int rs1, input int rs2);
    cur_k = k; cur_rd = rd; cur_rs1 = rs1; cur_rs2 = rs2;
    cur_v = 1'b1; cur_br = 1'b0; cur_xs = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_rd[i] = 0; m_ld[i] = 1'b0; end
    m_fa = 0; m_fb = 0; m_sc = 0; m_fc = 0;
  endtask

  // One cycle: drive at negedge, check Mealy outputs, clock, check registered outputs.
  task automatic step(input string tag);
    bit r1, r2, lu, fl, st, nv;
    int dest, na, nb;
    bus.id_valid  = cur_v;
    bus.id_instr  = enc(cur_k, cur_rd, cur_rs1, cur_rs2);
    bus.br_taken  = cur_br;
    bus.ext_stall = cur_xs;
    r1   = !(cur_k inside {K_JAL, K_LUI, K_AUIPC});
    r2   = cur_k inside {K_R, K_ST, K_BR};
    dest = (cur_k inside {K_ST, K_BR}) ? 0 : cur_rd;
    lu   = cur_v && (m_v[0] != 0) && m_ld[0] && (m_rd[0] != 0) &&
           ((r1 && cur_rs1 == m_rd[0]) || (r2 && cur_rs2 == m_rd[0]));
    fl   = cur_br && !cur_xs;
    st   = cur_xs || (lu && !fl);
    last_stall = st;
    #1;
    check({tag, ":stall_id"}, 32'(bus.stall_id), 32'(st));
    check({tag, ":flush_id"}, 32'(bus.flush_id), 32'(fl));
    @(posedge clk1);
    #1;
    if (!cur_xs) begin
      nv = cur_v && !fl && !lu;
      na = (nv && r1) ? src(cur_rs1) : 0;
      nb = (nv && r2) ? src(cur_rs2) : 0;
      if (lu && !fl && m_sc < CMAX) m_sc++;
      if (fl && m_fc < CMAX) m_fc++;
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_v[0] = nv; m_rd[0] = dest; m_ld[0] = (cur_k == K_LD);
      m_fa = na; m_fb = nb;
    end
    check({tag, ":fwd_a"}, 32'(bus.fwd_a_sel), m_fa);
    check({tag, ":fwd_b"}, 32'(bus.fwd_b_sel), m_fb);
    check({tag, ":stall_cnt"}, 32'(bus.stall_cnt), m_sc);
    check({tag, ":flush_cnt"}, 32'(bus.flush_cnt), m_fc);
    @(negedge clk1);
  endtask

  // Asynchronous reset pulse in the high clock phase with whatever inputs are driven.
  task automatic do_reset(input string tag);
    @(posedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, ":rst_stall_id"}, 32'(bus.stall_id), 0);
    check({tag, ":rst_flush_id"}, 32'(bus.flush_id), 0);
    check({tag, ":rst_fwd_a"}, 32'(bus.fwd_a_sel), 0);
    check({tag, ":rst_fwd_b"}, 32'(bus.fwd_b_sel), 0);
    check({tag, ":rst_stall_cnt"}, 32'(bus.stall_cnt), 0);
    check({tag, ":rst_flush_cnt"}, 32'(bus.flush_cnt), 0);
    model_clear();
    last_stall = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    bus.id_valid  = 1'b0;
    bus.id_instr  = 32'h0;
    bus.br_taken  = 1'b0;
    bus.ext_stall = 1'b1;
    #1;
    check("init:stall_id", 32'(bus.stall_id), 0);
    check("init:fwd_a", 32'(bus.fwd_a_sel), 0);
    check("init:stall_cnt", 32'(bus.stall_cnt), 0);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;

    // 1: add x3,x1,x2 ; add x4,x3,x5
    set_i(K_R, 3, 1, 2); step("t1a");
    set_i(K_R, 4, 3, 5); step("t1b");
    check("t1:fwd_a_exm", 32'(bus.fwd_a_sel), 1);
    check("t1:fwd_b_rf", 32'(bus.fwd_b_sel), 0);

    // 2: add x3,x1,x2 ; nop ; sub x6,x7,x3
    set_i(K_R, 3, 1, 2); step("t2a");
    set_i(K_I, 0, 0, 0); step("t2b");
    set_i(K_R, 6, 7, 3); step("t2c");
    check("t2:fwd_b_mwb", 32'(bus.fwd_b_sel), 2);

    // 3: lw x5,0(x1) ; add x6,x5,x7
    do_reset("t3");
    set_i(K_LD, 5, 1, 0); step("t3a");
    set_i(K_R, 6, 5, 7);  step("t3b");
    check("t3:stalled", 32'(last_stall), 1);
    step("t3c");
    check("t3:no_second_stall", 32'(last_stall), 0);
    check("t3:fwd_a_mwb", 32'(bus.fwd_a_sel), 2);
    check("t3:stall_cnt", 32'(bus.stall_cnt), 1);

    // 4: addi x0,x1,4 ; add x2,x0,x0
    set_i(K_I, 0, 1, 0); step("t4a");
    set_i(K_R, 2, 0, 0); step("t4b");
    check("t4:fwd_a", 32'(bus.fwd_a_sel), 0);
    check("t4:fwd_b", 32'(bus.fwd_b_sel), 0);

    // 5: load-use coinciding with a taken branch
    do_reset("t5");
    set_i(K_LD, 5, 1, 0); step("t5a");
    set_i(K_R, 6, 5, 7); cur_br = 1'b1; step("t5b");
    check("t5:flush_cnt", 32'(bus.flush_cnt), 1);
    check("t5:stall_cnt", 32'(bus.stall_cnt), 0);

    // 6: freeze during test 1, then reset mid-cycle
    set_i(K_R, 3, 1, 2); step("t6a");
    set_i(K_R, 4, 3, 5); cur_xs = 1'b1;
    for (int i = 0; i < 3; i++) step("t6frz");
    check("t6:frz_fwd_a", 32'(bus.fwd_a_sel), 0);
    check("t6:frz_flush_cnt", 32'(bus.flush_cnt), 1);
    cur_xs = 1'b0; step("t6go");
    check("t6:fwd_a_exm", 32'(bus.fwd_a_sel), 1);
    bus.ext_stall = 1'b1;
    bus.br_taken  = 1'b1;
    do_reset("t6");

    // Saturate the stall counter with repeated load-use pairs.
    for (int i = 0; i < CMAX + 4; i++) begin
      set_i(K_LD, 1, 2, 0); step("sat_ld");
      set_i(K_R, 3, 1, 1);  step("sat_use");
      step("sat_go");
    end
    check("sat:stall_cnt", 32'(bus.stall_cnt), CMAX);

    // Randomized streams over a small register set to provoke frequent hazards.
    set_i(K_I, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        set_i($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
        cur_v = ($urandom_range(0, 9) != 0);
      end
      cur_br = ($urandom_range(0, 99) < 15);
      cur_xs = ($urandom_range(0, 99) < 10);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the five-stage RV32I pipeline. It watches the instruction leaving decode, keeps a shadow record of what is in flight in EX, MEM and WB, and from that:
- selects forwarding operands for the execution stage,
- inserts load-use stall bubbles,
- flushes on taken branches,
- freezes on external memory stalls.

It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives their enables and operand muxes.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk1  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_instr  in  32  instruction in decode (RD_Instr of the decode stage).
- br_taken  in  1  EX stage resolved a taken branch or jump this cycle.
- ext_stall  in  1  data memory busy; whole pipeline frozen this cycle.
- stall_id  out  1  hold PC and IF/ID; combinational.
- flush_id  out  1  kill IF/ID contents; combinational.
- fwd_a_sel  out  2  EX operand A source, registered.
- fwd_b_sel  out  2  EX operand B source, registered.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  flush events, saturating.

## Operation
Decode of id_instr uses opcode[6:0], rd[11:7], rs1[19:15] and rs2[24:20].
- uses_rs1: all opcodes except LUI, AUIPC and JAL.
- uses_rs2: R-type, STORE and BRANCH.
- writes_rd: R-type, I-ALU, LOAD, JAL, JALR, LUI and AUIPC, and only when rd != 0.
- is_load: opcode 0000011.
- Register x0 never creates a hazard or a forward.

Shadow pipe has three entries, EX, MEM and WB. Each entry holds {valid, rd, wr, is_load}. On each unfrozen edge the entries shift ID→EX→MEM→WB.

Hazard and flush rules:
- Load-use: the ID instruction reads rsX == EX.rd, with EX.valid, EX.wr and EX.is_load all set.
  - stall_id=1.
  - A bubble (valid=0) enters shadow EX.
  - The ID instruction is held.
  - stall_cnt increments.
- Taken branch: br_taken=1.
  - flush_id=1.
  - A bubble enters shadow EX.
  - flush_cnt increments.
  - Flush wins over load-use: stall_id=0 and stall_cnt does not increment.
- ext_stall=1:
  - No shift occurs.
  - fwd_a_sel, fwd_b_sel and the counters hold.
  - stall_id=1 and flush_id=0.
  - br_taken is ignored; EX holds the branch until the freeze ends.

Forwarding select encoding:
- 00: register file.
- 01: EX/MEM result.
- 10: MEM/WB writeback.
- Selects are computed in ID against shadow EX (becomes 01) and shadow MEM (becomes 10), and registered with the shift.
- If both match, the newest wins (01).
- A load in EX is never forwarded as 01, because the stall prevents that case.
- When the incoming EX entry is a bubble, both selects register as 00.

Counters saturate at all-ones.

## Timing
- Reset (asynchronous, rst_n=0):
  - All shadow valid bits 0.
  - fwd_a_sel and fwd_b_sel = 00.
  - Both counters 0.
  - stall_id and flush_id = 0 while in reset.
  - Takes effect immediately, including mid-stall or mid-flush.
  - After release, the first edge shifts normally.
- stall_id and flush_id are Mealy outputs: valid in the same cycle as the causing inputs.
- fwd_*_sel updates on the edge where the instruction enters EX and is valid for its whole EX cycle.
- A load-use stall lasts exactly 1 cycle. The next cycle the dependency sits in MEM, so the select is 10.
- Counters are visible one edge after the event.
- Back-to-back taken branches give one flush per cycle in which br_taken=1.

## Structure
- Package hz_pkg holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - Forwarding encodings: FWD_RF, FWD_EXM, FWD_MWB.
  - The shadow-entry struct.
- Sub-module hz_decode is the combinational field decoder producing rs1, rs2, rd, uses_rs1, uses_rs2, writes_rd and is_load. It is reused by the top-level control unit.

## Test plan
1. add x3,x1,x2 then add x4,x3,x5 back-to-back → in the second instruction's EX cycle, fwd_a_sel=01 and fwd_b_sel=00.
2. add x3,x1,x2; nop; sub x6,x7,x3 → fwd_b_sel=10 in sub's EX cycle; no stall.
3. lw x5,0(x1) then add x6,x5,x7 → stall_id=1 for exactly 1 cycle, one bubble, then fwd_a_sel=10; stall_cnt=1.
4. addi x0,x1,4 then add x2,x0,x0 → both selects 00, stall_id=0.
5. Load-use hazard present in the same cycle as br_taken=1 → flush_id=1, stall_id=0, flush_cnt=1, stall_cnt=0.
6. ext_stall=1 for 3 cycles during test 1, then rst_n pulsed low mid-sequence:
   - During the freeze, selects and counters hold.
   - On reset, all outputs return to 0 asynchronously.
